// File: rtl/cordic_arbiter_if.sv
// Bundle of client request/response lines and the CORDIC engine handshake
// shared by cordic_arbiter (slave side) and whoever drives the clients/engine.
interface cordic_arbiter_if #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ANG_W = 16
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ*IN_W-1:0] req_x;
    logic [N_REQ*IN_W-1:0] req_y;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      rsp_valid;
    logic [ANG_W-1:0]      rsp_angle;
    logic                  rsp_timeout;
    logic                  busy;
    logic                  cor_start;
    logic [IN_W-1:0]       cor_x;
    logic [IN_W-1:0]       cor_y;
    logic                  cor_ready;
    logic                  cor_done;
    logic [ANG_W-1:0]      cor_angle;

    modport slave (
        input  req, req_x, req_y, cor_ready, cor_done, cor_angle,
        output gnt, rsp_valid, rsp_angle, rsp_timeout, busy,
               cor_start, cor_x, cor_y
    );

    modport master (
        output req, req_x, req_y, cor_ready, cor_done, cor_angle,
        input  gnt, rsp_valid, rsp_angle, rsp_timeout, busy,
               cor_start, cor_x, cor_y
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one CORDIC angle engine between N_REQ clients, with a
// WAIT watchdog so a hung engine still returns an (aborted) response.
module cordic_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned ANG_W   = 16,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic            clk,
    input  logic            reset,
    cordic_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_d;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_d;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] scan_idx;
    logic             any_req;
    logic             timed_out;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_d;

    logic [IN_W-1:0]  x_reg;
    logic [IN_W-1:0]  y_reg;
    logic [IN_W-1:0]  x_d;
    logic [IN_W-1:0]  y_d;
    logic [IN_W-1:0]  sel_x;
    logic [IN_W-1:0]  sel_y;

    logic [N_REQ-1:0] gnt_c;
    logic             cor_start_c;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [N_REQ-1:0] rsp_valid_d;
    logic [ANG_W-1:0] rsp_angle_q;
    logic [ANG_W-1:0] rsp_angle_d;
    logic             rsp_timeout_q;
    logic             rsp_timeout_d;
    logic             busy_q;

    assign any_req   = |bus.req;
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

    // Round-robin pick: first set request at or after rr_ptr, wrapping upward.
    // Scanning from the far end down lets the nearest candidate win last.
    always_comb begin
        winner   = rr_ptr;
        scan_idx = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((32'(rr_ptr) + 32'(k)) % N_REQ);
            if (bus.req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Operand mux for the winning client.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (PTR_W'(i) == winner) begin
                sel_x = bus.req_x[i*IN_W +: IN_W];
                sel_y = bus.req_y[i*IN_W +: IN_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; done beats the watchdog when both land together.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bus.cor_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.cor_done || timed_out) begin
                    state_nxt = S_DELIVER;
                end
            end
            S_DELIVER: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: gnt/cor_start are combinational, the rest feed registers.
    always_comb begin
        gnt_c         = '0;
        cor_start_c   = 1'b0;
        rr_ptr_d      = rr_ptr;
        owner_d       = owner;
        x_d           = x_reg;
        y_d           = y_reg;
        wait_cnt_d    = '0;
        rsp_valid_d   = '0;
        rsp_angle_d   = rsp_angle_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state)
            S_IDLE: begin
                if (any_req && !reset) begin
                    gnt_c    = N_REQ'(1'b1) << winner;
                    owner_d  = winner;
                    rr_ptr_d = PTR_W'((32'(winner) + 32'd1) % N_REQ);
                    x_d      = sel_x;
                    y_d      = sel_y;
                end
            end
            S_START: begin
                cor_start_c = bus.cor_ready;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt + CNT_W'(1);
                if (bus.cor_done) begin
                    rsp_angle_d   = bus.cor_angle;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = N_REQ'(1'b1) << owner;
                end else if (timed_out) begin
                    rsp_angle_d   = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = N_REQ'(1'b1) << owner;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and registered outputs; wait_cnt is zero whenever not in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr        <= '0;
            owner         <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            wait_cnt      <= '0;
            rsp_valid_q   <= '0;
            rsp_angle_q   <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rr_ptr        <= rr_ptr_d;
            owner         <= owner_d;
            x_reg         <= x_d;
            y_reg         <= y_d;
            wait_cnt      <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_angle_q   <= rsp_angle_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= (state_nxt != S_IDLE);
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.cor_start   = cor_start_c;
    assign bus.cor_x       = x_reg;
    assign bus.cor_y       = y_reg;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_angle   = rsp_angle_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = busy_q;

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares the single CORDIC angle engine between up to N_REQ phase-measurement clients, such as the AFC frequency-correction loop and a demodulator phase tap. A round-robin arbiter accepts one request at a time and latches that client's I/Q operands. It then sequences the engine's start/ready/done handshake and returns the angle to the granted client with a one-cycle valid strobe. A watchdog timeout keeps a hung engine from deadlocking the clients.

## Interface
- N_REQ, 2: number of requesters (2..4)
- IN_W, 8: signed I/Q operand width
- ANG_W, 16: signed angle width
- TIMEOUT, 31: maximum WAIT cycles before aborting (1..255)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-client request; held high until granted
- req_x  in  N_REQ*IN_W  in-phase operands; client i in slice [i*IN_W +: IN_W]
- req_y  in  N_REQ*IN_W  quadrature operands, same packing
- gnt  out  N_REQ  one-hot accept strobe; operands are captured on this cycle's edge
- rsp_valid  out  N_REQ  one-hot, one-cycle result strobe to the owning client
- rsp_angle  out  ANG_W  result angle; held from one delivery until the next
- rsp_timeout  out  1  qualifies rsp_valid: 1 = aborted, and rsp_angle = 0
- busy  out  1  high in every state except IDLE
- cor_start  out  1  engine start pulse
- cor_x, cor_y  out  IN_W  engine operands, driven from the operand registers
- cor_ready  in  1  engine can accept start
- cor_done  in  1  engine result valid this cycle
- cor_angle  in  ANG_W  engine result

## Operation
- FSM states: IDLE, START, WAIT, DELIVER.
- IDLE → START:
  - Taken when any req bit is high.
  - Winner = first set bit at or after rr_ptr, scanning upward with wrap.
  - gnt[winner] is combinational in that IDLE cycle.
  - On that edge: operands → x_reg/y_reg, owner ← winner, rr_ptr ← (winner+1) mod N_REQ.
- START:
  - cor_start is combinationally high while in START and cor_ready=1; the FSM moves to WAIT on that edge.
  - With cor_ready=0 the FSM stays in START and cor_start stays low.
- WAIT:
  - Timeout counter clears on entry and increments each cycle.
  - cor_done=1: rsp_angle ← cor_angle, rsp_timeout ← 0, go to DELIVER.
  - Counter reaches TIMEOUT without done: rsp_angle ← 0, rsp_timeout ← 1, go to DELIVER.
  - cor_done and timeout in the same cycle: done wins.
- DELIVER: rsp_valid[owner]=1 for exactly one cycle, then IDLE.
- cor_done arriving outside WAIT is ignored; a late done after a timeout is discarded.
- The FSM accepts requests only in IDLE. A req still high after its gnt is treated as a new request at the next IDLE.
- No operand arithmetic: operands pass through unchanged; widths are fixed by the parameters.
- Reset (async, any state):
  - FSM → IDLE, rr_ptr=0, counter=0.
  - x_reg=y_reg=0, rsp_angle=0, rsp_timeout=0.
  - rsp_valid=0, cor_start=0, busy=0.
  - gnt is forced 0 while reset is high.
  - An in-flight transaction is dropped with no response.

## Timing
- Request at cycle t (IDLE, cor_ready=1, engine takes L cycles start→done):
  - gnt at t
  - cor_start at t+1
  - cor_done at t+1+L
  - rsp_valid at t+2+L
- Minimum request-to-response: 3 cycles (L=1).
- Back-to-back throughput: one transaction per L+3 cycles.
- Timeout path: rsp_valid TIMEOUT+1 cycles after entering WAIT.
- All outputs except gnt and cor_start are registered; gnt and cor_start are decoded from the registered state plus the current inputs.

## Test plan
- Single request: client 0, x=8'sd100, y=8'sd0, engine L=10 returning 16'h0000 → gnt[0] at t, cor_start at t+1, rsp_valid[0] at t+12, rsp_angle=0, rsp_timeout=0.
- Contention:
  - req=2'b11 held continuously with rr_ptr=0 → grants alternate 0,1,0,1.
  - Each rsp_valid reaches the matching owner with its own operand-derived angle.
  - No client waits more than one transaction.
- Ready stall: cor_ready low for 5 cycles after gnt → cor_start held off 5 cycles, then pulses once; response delayed exactly 5 cycles.
- Timeout:
  - Engine never asserts done, TIMEOUT=31 → rsp_valid with rsp_timeout=1 and rsp_angle=0, 32 cycles after WAIT entry.
  - A done injected 3 cycles later is ignored and busy stays 0.
- Done/timeout collision: cor_done=1 with cor_angle=16'h1680 on the timeout cycle → rsp_angle=16'h1680, rsp_timeout=0.
- Reset mid-WAIT: assert reset asynchronously between edges → outputs go to reset values immediately, no rsp_valid appears, and the next request from client 1 is granted with rr_ptr restarted at 0.
